// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the pattern scan controller and its matcher.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SCAN,
        DONE
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 16;

    // Counts stick at maxVal instead of wrapping back to zero.
    function automatic logic [31:0] satInc(input logic [31:0] value, input logic [31:0] maxVal);
        return (value >= maxVal) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pattern_shift_matcher.sv
// Serial history register with a fill counter and a registered compare against
// the low len bits of the pattern; o_match pulses the cycle after the completing bit.
module pattern_shift_matcher
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_bit_in,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_match
);

    logic [PAT_W-1:0] r_history;
    logic [LEN_W-1:0] r_fill;
    logic             r_match;

    logic [PAT_W-1:0] w_nextHistory;
    logic [LEN_W-1:0] w_nextFill;
    logic             w_equal;

    assign w_nextHistory = {r_history[PAT_W-2:0], i_bit_in};
    assign w_nextFill    = LEN_W'(satInc(32'(r_fill), 32'(PAT_W)));

    // Compare against the history as it will look after this bit shifts in.
    always_comb begin
        w_equal = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(i_len) && w_nextHistory[i] != i_pattern[i]) begin
                w_equal = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_history <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else if (i_clr) begin
            r_history <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else if (i_shift_en) begin
            r_history <= w_nextHistory;
            r_fill    <= w_nextFill;
            r_match   <= w_equal && (w_nextFill >= i_len);
        end else begin
            r_match   <= 1'b0;
        end
    end

    assign o_match = r_match;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan-window controller around pattern_shift_matcher: counts overlapping matches and first position.
// Optional abort port and sticky aborted flag when PAT_SCAN_ABORT_EN is defined.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic [CNT_W-1:0] i_cfg_window,
    input  logic             i_start,
    input  logic             i_stream_valid,
    input  logic             i_stream_in,
`ifdef PAT_SCAN_ABORT_EN
    input  logic             i_abort,
    output logic             o_aborted,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pattern_found,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_first_valid,
    output logic [CNT_W-1:0] o_first_pos
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] MAX_COUNT = '1;

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_patLen;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_bitCount;
    logic [CNT_W-1:0] r_matchCount;
    logic [CNT_W-1:0] r_firstPos;
    logic             r_firstValid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_clampLen;
    logic [CNT_W-1:0] w_nextBitCount;
    logic             w_abort;
    logic             w_shift;
    logic             w_clr;
    logic             w_match;

    always_comb begin
        w_clampLen = i_cfg_len;
        if (i_cfg_len == '0) begin
            w_clampLen = LEN_W'(1);
        end else if (i_cfg_len > MAX_LEN) begin
            w_clampLen = MAX_LEN;
        end
    end

`ifdef PAT_SCAN_ABORT_EN
    logic r_aborted;
    assign w_abort   = i_abort && (r_state == ARM || r_state == SCAN);
    assign o_aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign w_nextBitCount = r_bitCount + 1'b1;
    assign w_shift        = (r_state == SCAN) && i_stream_valid && !w_abort;
    assign w_clr          = (r_state == IDLE) && i_start;

    pattern_shift_matcher #(
        .PAT_W(PAT_W)
    ) u_matcher (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (w_clr),
        .i_shift_en (w_shift),
        .i_bit_in   (i_stream_in),
        .i_pattern  (r_pattern),
        .i_len      (r_patLen),
        .o_match    (w_match)
    );

    // A match pulse lands one cycle after its bit, so r_bitCount already points one past it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_pattern    <= '0;
            r_patLen     <= '0;
            r_window     <= '0;
            r_bitCount   <= '0;
            r_matchCount <= '0;
            r_firstPos   <= '0;
            r_firstValid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef PAT_SCAN_ABORT_EN
            r_aborted    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_match) begin
                r_matchCount <= CNT_W'(satInc(32'(r_matchCount), 32'(MAX_COUNT)));
                if (!r_firstValid) begin
                    r_firstValid <= 1'b1;
                    r_firstPos   <= r_bitCount - 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pattern    <= i_cfg_pattern;
                        r_patLen     <= w_clampLen;
                        r_window     <= i_cfg_window;
                        r_bitCount   <= '0;
                        r_matchCount <= '0;
                        r_firstValid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ARM;
`ifdef PAT_SCAN_ABORT_EN
                        r_aborted    <= 1'b0;
`endif
                    end
                end
                ARM: begin
                    if (w_abort || r_window == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= SCAN;
                    end
`ifdef PAT_SCAN_ABORT_EN
                    if (w_abort) r_aborted <= 1'b1;
`endif
                end
                SCAN: begin
                    if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (i_stream_valid) begin
                        r_bitCount <= w_nextBitCount;
                        if (w_nextBitCount == r_window) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
`ifdef PAT_SCAN_ABORT_EN
                    if (w_abort) r_aborted <= 1'b1;
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pattern_found = w_match;
    assign o_match_count   = r_matchCount;
    assign o_first_valid   = r_firstValid;
    assign o_first_pos     = r_firstPos;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl; expectations are queued at stimulus and popped at done.
module tb_pattern_scan_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [PAT_W-1:0] i_cfg_pattern;
    logic [LEN_W-1:0] i_cfg_len;
    logic [CNT_W-1:0] i_cfg_window;
    logic             i_start;
    logic             i_stream_valid;
    logic             i_stream_in;
    logic             o_busy;
    logic             o_done;
    logic             o_pattern_found;
    logic [CNT_W-1:0] o_match_count;
    logic             o_first_valid;
    logic [CNT_W-1:0] o_first_pos;
`ifdef PAT_SCAN_ABORT_EN
    logic             i_abort;
    logic             o_aborted;
`endif

    pattern_scan_ctrl #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cfg_pattern  (i_cfg_pattern),
        .i_cfg_len      (i_cfg_len),
        .i_cfg_window   (i_cfg_window),
        .i_start        (i_start),
        .i_stream_valid (i_stream_valid),
        .i_stream_in    (i_stream_in),
`ifdef PAT_SCAN_ABORT_EN
        .i_abort        (i_abort),
        .o_aborted      (o_aborted),
`endif
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pattern_found(o_pattern_found),
        .o_match_count  (o_match_count),
        .o_first_valid  (o_first_valid),
        .o_first_pos    (o_first_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    count;
        int    firstValid;
        int    firstPos;
        int    pulses;
        int    aborted;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pulseCount = 0;
    int   doneCount = 0;
    int   pulseBase = 0;

    bit basicBits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(negedge clk) begin
        if (o_pattern_found === 1'b1) pulseCount++;
        if (o_done === 1'b1) doneCount++;
    end

    function automatic exp_t makeExp(input string tag, input int count, input int fv,
                                     input int fp, input int pulses, input int ab);
        exp_t e;
        e.tag = tag; e.count = count; e.firstValid = fv;
        e.firstPos = fp; e.pulses = pulses; e.aborted = ab;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                                 input logic [CNT_W-1:0] window);
        @(posedge clk); #1;
        pulseBase     = pulseCount;
        i_cfg_pattern = pat;
        i_cfg_len     = len;
        i_cfg_window  = window;
        i_start       = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sendBit(input bit b, input int gap);
        i_stream_valid = 1'b1;
        i_stream_in    = b;
        @(posedge clk); #1;
        i_stream_valid = 1'b0;
        i_stream_in    = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic finishScan();
        int   waited = 0;
        exp_t e;
        while (o_done !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        e = scoreboard.pop_front();
        checkOutput({e.tag, "_done"}, o_done, 1);
        checkOutput({e.tag, "_done_latency"}, waited, 0);
        checkOutput({e.tag, "_busy_at_done"}, o_busy, 0);
        @(posedge clk); #1;
        checkOutput({e.tag, "_done_width"}, o_done, 0);
        checkOutput({e.tag, "_match_count"}, o_match_count, e.count);
        checkOutput({e.tag, "_first_valid"}, o_first_valid, e.firstValid);
        if (e.firstValid != 0) checkOutput({e.tag, "_first_pos"}, o_first_pos, e.firstPos);
        checkOutput({e.tag, "_pulses"}, pulseCount - pulseBase, e.pulses);
`ifdef PAT_SCAN_ABORT_EN
        checkOutput({e.tag, "_aborted"}, o_aborted, e.aborted);
`endif
    endtask

    task automatic runBasic(input string tag, input bit injectStart);
        scoreboard.push_back(makeExp(tag, 2, 1, 3, 2, 0));
        applyStimulus(8'b0000_1011, 4'd4, 16'd8);
        for (int i = 0; i < 8; i++) begin
            sendBit(basicBits[i], 0);
            if (injectStart && i == 3) begin
                i_start      = 1'b1;
                i_cfg_window = 16'd3;
                i_cfg_len    = 4'd1;
                @(posedge clk); #1;
                i_start = 1'b0;
                checkOutput({tag, "_busy_after_restart"}, o_busy, 1);
            end
        end
        finishScan();
    endtask

    // Independent reference: plain shift-and-compare over the accepted bits.
    task automatic runRandom(input int idx);
        bit          bits[$];
        int          len, window, hist, fill, mask, cnt, fv, fp;
        logic [7:0]  pat;
        len    = $urandom_range(1, 8);
        window = $urandom_range(12, 20);
        pat    = 8'($urandom);
        for (int i = 0; i < window; i++) begin
            if ($urandom_range(0, 2) != 0) bits.push_back(pat[(len - 1) - (i % len)]);
            else bits.push_back(1'($urandom_range(0, 1)));
        end
        hist = 0; fill = 0; cnt = 0; fv = 0; fp = 0;
        mask = (1 << len) - 1;
        for (int i = 0; i < window; i++) begin
            hist = ((hist << 1) | int'(bits[i])) & 255;
            if (fill < 8) fill++;
            if (fill >= len && (hist & mask) == (int'(pat) & mask)) begin
                cnt++;
                if (fv == 0) begin fv = 1; fp = i; end
            end
        end
        scoreboard.push_back(makeExp($sformatf("rand%0d", idx), cnt, fv, fp, cnt, 0));
        applyStimulus(pat, LEN_W'(len), CNT_W'(window));
        for (int i = 0; i < window; i++) begin
            sendBit(bits[i], (i == window - 1) ? 0 : $urandom_range(0, 1));
        end
        finishScan();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  doneBase;
        bit  zeros[10] = '{default: 1'b0};
        bit  ovBits[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bit  len0Bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit  len12Bits[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        reset          = 1'b1;
        i_cfg_pattern  = '0;
        i_cfg_len      = '0;
        i_cfg_window   = '0;
        i_start        = 1'b0;
        i_stream_valid = 1'b0;
        i_stream_in    = 1'b0;
`ifdef PAT_SCAN_ABORT_EN
        i_abort        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_found", o_pattern_found, 0);
        checkOutput("reset_count", o_match_count, 0);
        checkOutput("reset_first_valid", o_first_valid, 0);
        checkOutput("reset_first_pos", o_first_pos, 0);
        reset = 1'b0;

        runBasic("basic", 1'b0);

        scoreboard.push_back(makeExp("overlap", 2, 1, 2, 2, 0));
        applyStimulus(8'b101, 4'd3, 16'd6);
        for (int i = 0; i < 6; i++) begin
            sendBit(ovBits[i], (i == 5) ? 0 : 2);
            if (i == 2) begin
                checkOutput("gap_hold_count", o_match_count, 1);
                checkOutput("gap_hold_pos", o_first_pos, 2);
                checkOutput("gap_hold_busy", o_busy, 1);
            end
        end
        finishScan();

        scoreboard.push_back(makeExp("fill", 3, 1, 7, 3, 0));
        applyStimulus(8'h00, 4'd8, 16'd10);
        for (int i = 0; i < 10; i++) sendBit(zeros[i], 0);
        finishScan();

        scoreboard.push_back(makeExp("win0", 0, 0, 0, 0, 0));
        applyStimulus(8'hFF, 4'd1, 16'd0);
        finishScan();

        scoreboard.push_back(makeExp("len0", 3, 1, 0, 3, 0));
        applyStimulus(8'h01, 4'd0, 16'd4);
        for (int i = 0; i < 4; i++) sendBit(len0Bits[i], 0);
        finishScan();

        scoreboard.push_back(makeExp("len12", 1, 1, 7, 1, 0));
        applyStimulus(8'hA5, 4'd12, 16'd10);
        for (int i = 0; i < 10; i++) sendBit(len12Bits[i], 0);
        finishScan();

        runBasic("restart_ignored", 1'b1);

        applyStimulus(8'b0000_1011, 4'd4, 16'd8);
        for (int i = 0; i < 3; i++) sendBit(basicBits[i], 0);
        doneBase = doneCount;
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy", o_busy, 0);
        checkOutput("midreset_done", o_done, 0);
        checkOutput("midreset_count", o_match_count, 0);
        checkOutput("midreset_first_valid", o_first_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset_no_done", doneCount - doneBase, 0);
        checkOutput("midreset_idle_busy", o_busy, 0);
        runBasic("after_reset", 1'b0);

        for (int r = 0; r < 3; r++) runRandom(r);

`ifdef PAT_SCAN_ABORT_EN
        scoreboard.push_back(makeExp("abort", 1, 1, 3, 1, 1));
        applyStimulus(8'b0000_1011, 4'd4, 16'd8);
        for (int i = 0; i < 5; i++) sendBit(basicBits[i], 0);
        i_abort        = 1'b1;
        i_stream_valid = 1'b1;
        i_stream_in    = 1'b1;
        @(posedge clk); #1;
        i_abort        = 1'b0;
        i_stream_valid = 1'b0;
        i_stream_in    = 1'b0;
        finishScan();
        scoreboard.push_back(makeExp("post_abort", 0, 0, 0, 0, 0));
        applyStimulus(8'h00, 4'd1, 16'd0);
        finishScan();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
